// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared async FIFO constants and Gray-code helpers
//
// Purpose: default FIFO depth and the binary/Gray conversion functions used by
// both pointer domains.
// Ports: none (package).
package fifo_pkg;

    localparam int FIFO_ADDR_WIDTH = 3;

    // Helpers operate on a 32-bit container. Any narrower pointer is
    // zero-extended into it and truncated back by the caller. Zero upper bits
    // do not disturb either conversion, so one pair of functions covers every
    // pointer width.
    localparam int PTR_MAX_W = 32;

    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] gray);
        logic [PTR_MAX_W-1:0] bin;
        logic                 acc;
        bin = '0;
        acc = 1'b0;
        for (int i = PTR_MAX_W - 1; i >= 0; i--) begin
            acc    = acc ^ gray[i];
            bin[i] = acc;
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// rtl/fifo_gray2bin.sv - combinational Gray-to-binary converter
//
// Purpose: converts a Gray-coded FIFO pointer to binary. It is shared by the
// write-side full logic and the read-side empty logic.
// Ports:
//   GRAY  input  [WIDTH-1:0]  Gray-coded pointer
//   BIN   output [WIDTH-1:0]  binary equivalent
module fifo_gray2bin #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] GRAY,
    output logic [WIDTH-1:0] BIN
);

    // Each binary bit is the XOR of all Gray bits at and above it. A running
    // scalar carries the prefix, which avoids a vector that feeds back on
    // itself.
    always_comb begin
        logic acc;
        acc = 1'b0;
        BIN = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            acc    = acc ^ GRAY[i];
            BIN[i] = acc;
        end
    end

endmodule

// File: rtl/fifo_wr_ptr_full.sv
// rtl/fifo_wr_ptr_full.sv - async FIFO write-domain pointer and full/level logic
//
// Purpose: keeps the binary and Gray write pointers and produces the memory
// write strobe and address. It derives FULL, ALMOST_FULL, the fill level and a
// sticky overflow flag from the synchronized read Gray pointer.
// Ports:
//   CLK          input                 write-domain clock
//   RST          input                 asynchronous active-low reset
//   W_INC        input                 producer write request
//   WQ2_RPTR     input  [ADDR_WIDTH:0] read Gray pointer, synchronized to CLK
//   W_EN         output                memory write strobe (combinational)
//   W_ADDR       output [ADDR_WIDTH-1:0] memory write address
//   WPTR_GRAY    output [ADDR_WIDTH:0] registered Gray write pointer
//   FULL         output                registered full flag
//   ALMOST_FULL  output                registered level >= AF_THRESHOLD
//   W_LEVEL      output [ADDR_WIDTH:0] registered fill level, 0..2^ADDR_WIDTH
//   OVERFLOW     output                sticky write-while-full flag
module fifo_wr_ptr_full
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH   = FIFO_ADDR_WIDTH,
    parameter int AF_THRESHOLD = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  W_INC,
    input  logic [ADDR_WIDTH:0]   WQ2_RPTR,
    output logic                  W_EN,
    output logic [ADDR_WIDTH-1:0] W_ADDR,
    output logic [ADDR_WIDTH:0]   WPTR_GRAY,
    output logic                  FULL,
    output logic                  ALMOST_FULL,
    output logic [ADDR_WIDTH:0]   W_LEVEL,
    output logic                  OVERFLOW
);

    localparam int PTR_W = ADDR_WIDTH + 1;
    localparam logic [PTR_W-1:0] AF_LEVEL = PTR_W'(AF_THRESHOLD);

    logic [PTR_W-1:0] wbin_q,  wbin_d;
    logic [PTR_W-1:0] wgray_q, wgray_d;
    logic             full_q,  full_d;
    logic             af_q,    af_d;
    logic [PTR_W-1:0] level_q, level_d;
    logic             ovf_q,   ovf_d;

    logic [PTR_W-1:0] rbin;
    logic [PTR_W-1:0] rptr_full_cmp;
    logic             w_accept;

    fifo_gray2bin #(
        .WIDTH (PTR_W)
    ) u_rptr_gray2bin (
        .GRAY (WQ2_RPTR),
        .BIN  (rbin)
    );

    // RST is ANDed in so that the strobe is held low during reset, even while
    // the producer holds W_INC high.
    assign w_accept = RST & W_INC & ~full_q;

    // The FIFO is full when the write pointer has lapped the read pointer by
    // exactly one depth. In Gray code that is the read pointer with its top
    // two bits inverted.
    assign rptr_full_cmp = {~WQ2_RPTR[ADDR_WIDTH:ADDR_WIDTH-1], WQ2_RPTR[ADDR_WIDTH-2:0]};

    always_comb begin
        wbin_d  = wbin_q + {{ADDR_WIDTH{1'b0}}, w_accept};
        wgray_d = PTR_W'(bin2gray(PTR_MAX_W'(wbin_d)));
        full_d  = (wgray_d == rptr_full_cmp);
        // Modular subtraction is exact across pointer wrap because the extra
        // MSB keeps full (2^ADDR_WIDTH) distinct from empty (0).
        level_d = wbin_d - rbin;
        af_d    = (level_d >= AF_LEVEL);
        ovf_d   = ovf_q | (W_INC & full_q);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            full_q  <= full_d;
            af_q    <= af_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
        end
    end

    // WPTR_GRAY crosses clock domains. It comes straight from its flops so that
    // only one bit can change per edge.
    assign W_EN        = w_accept;
    assign W_ADDR      = wbin_q[ADDR_WIDTH-1:0];
    assign WPTR_GRAY   = wgray_q;
    assign FULL        = full_q;
    assign ALMOST_FULL = af_q;
    assign W_LEVEL     = level_q;
    assign OVERFLOW    = ovf_q;

endmodule

// File: tb/tb_fifo_wr_ptr_full.sv
// tb/tb_fifo_wr_ptr_full.sv - self-checking bench for fifo_wr_ptr_full
module tb_fifo_wr_ptr_full;

    logic       CLK;
    logic       RST;
    logic       W_INC;
    logic [3:0] WQ2_RPTR;
    logic       W_EN;
    logic [2:0] W_ADDR;
    logic [3:0] WPTR_GRAY;
    logic       FULL;
    logic       ALMOST_FULL;
    logic [3:0] W_LEVEL;
    logic       OVERFLOW;

    int n_vec  = 0;
    int n_miss = 0;

    fifo_wr_ptr_full #(
        .ADDR_WIDTH   (3),
        .AF_THRESHOLD (6)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .W_INC       (W_INC),
        .WQ2_RPTR    (WQ2_RPTR),
        .W_EN        (W_EN),
        .W_ADDR      (W_ADDR),
        .WPTR_GRAY   (WPTR_GRAY),
        .FULL        (FULL),
        .ALMOST_FULL (ALMOST_FULL),
        .W_LEVEL     (W_LEVEL),
        .OVERFLOW    (OVERFLOW)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0] gray;
        logic       full;
        logic       af;
        logic [3:0] level;
        logic       ovf;
    } exp_t;

    typedef struct {
        logic       w_inc;
        logic [3:0] rptr;
        logic       wen;
        logic [2:0] addr;
        exp_t       post;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];

    function automatic exp_t mk_exp(logic [3:0] gray, logic full, logic af,
                                    logic [3:0] level, logic ovf);
        exp_t e;
        e.gray  = gray;
        e.full  = full;
        e.af    = af;
        e.level = level;
        e.ovf   = ovf;
        return e;
    endfunction

    function automatic void add_vec(logic w_inc, logic [3:0] rptr, logic wen,
                                    logic [2:0] addr, exp_t post);
        vec_t v;
        v.w_inc = w_inc;
        v.rptr  = rptr;
        v.wen   = wen;
        v.addr  = addr;
        v.post  = post;
        vecs.push_back(v);
    endfunction

    function automatic logic [3:0] to_gray(int b);
        logic [3:0] v;
        v = 4'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_post(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            check({tag, " WPTR_GRAY"},   32'(WPTR_GRAY),   32'(e.gray));
            check({tag, " FULL"},        32'(FULL),        32'(e.full));
            check({tag, " ALMOST_FULL"}, 32'(ALMOST_FULL), 32'(e.af));
            check({tag, " W_LEVEL"},     32'(W_LEVEL),     32'(e.level));
            check({tag, " OVERFLOW"},    32'(OVERFLOW),    32'(e.ovf));
        end
    endtask

    // One clock of stimulus. Inputs change on the falling edge, and the
    // combinational strobe/address are checked there. The registered
    // expectation is queued and compared 1 ns after the rising edge.
    task automatic step(input string tag, input logic w_inc, input logic [3:0] rptr,
                        input logic wen, input logic [2:0] addr, input exp_t post);
        @(negedge CLK);
        W_INC    = w_inc;
        WQ2_RPTR = rptr;
        #1;
        check({tag, " W_EN"},   32'(W_EN),   32'(wen));
        check({tag, " W_ADDR"}, 32'(W_ADDR), 32'(addr));
        sb.push_back(post);
        @(posedge CLK);
        #1;
        check_post(tag);
    endtask

    initial begin
        logic [3:0] prev_gray;
        int         wr_cnt;
        int         rd_cnt;
        int         wb;
        int         lvl;
        exp_t       e;

        // 8 back-to-back writes against an empty reader.
        add_vec(1, 4'b0000, 1, 3'd0, mk_exp(4'b0001, 0, 0, 4'd1, 0));
        add_vec(1, 4'b0000, 1, 3'd1, mk_exp(4'b0011, 0, 0, 4'd2, 0));
        add_vec(1, 4'b0000, 1, 3'd2, mk_exp(4'b0010, 0, 0, 4'd3, 0));
        add_vec(1, 4'b0000, 1, 3'd3, mk_exp(4'b0110, 0, 0, 4'd4, 0));
        add_vec(1, 4'b0000, 1, 3'd4, mk_exp(4'b0111, 0, 0, 4'd5, 0));
        add_vec(1, 4'b0000, 1, 3'd5, mk_exp(4'b0101, 0, 1, 4'd6, 0));
        add_vec(1, 4'b0000, 1, 3'd6, mk_exp(4'b0100, 0, 1, 4'd7, 0));
        add_vec(1, 4'b0000, 1, 3'd7, mk_exp(4'b1100, 1, 1, 4'd8, 0));
        // Writes while full are rejected, and overflow sticks.
        add_vec(1, 4'b0000, 0, 3'd0, mk_exp(4'b1100, 1, 1, 4'd8, 1));
        add_vec(1, 4'b0000, 0, 3'd0, mk_exp(4'b1100, 1, 1, 4'd8, 1));
        add_vec(0, 4'b0000, 0, 3'd0, mk_exp(4'b1100, 1, 1, 4'd8, 1));
        // Read advance frees a slot, and a refill makes the FIFO full again.
        add_vec(0, 4'b0001, 0, 3'd0, mk_exp(4'b1100, 0, 1, 4'd7, 1));
        add_vec(1, 4'b0001, 1, 3'd0, mk_exp(4'b1101, 1, 1, 4'd8, 1));
        add_vec(0, 4'b0011, 0, 3'd1, mk_exp(4'b1101, 0, 1, 4'd7, 1));
        // A write and a read advance in the same cycle leave the level unchanged.
        add_vec(1, 4'b0010, 1, 3'd1, mk_exp(4'b1111, 0, 1, 4'd7, 1));
        add_vec(1, 4'b0010, 1, 3'd2, mk_exp(4'b1110, 1, 1, 4'd8, 1));

        // Reset while a write is requested.
        RST      = 1'b0;
        W_INC    = 1'b1;
        WQ2_RPTR = 4'b0000;
        #12;
        check("reset W_EN",        32'(W_EN),        32'd0);
        check("reset W_ADDR",      32'(W_ADDR),      32'd0);
        check("reset WPTR_GRAY",   32'(WPTR_GRAY),   32'd0);
        check("reset FULL",        32'(FULL),        32'd0);
        check("reset ALMOST_FULL", 32'(ALMOST_FULL), 32'd0);
        check("reset W_LEVEL",     32'(W_LEVEL),     32'd0);
        check("reset OVERFLOW",    32'(OVERFLOW),    32'd0);
        @(negedge CLK);
        RST   = 1'b1;
        W_INC = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d", i), vecs[i].w_inc, vecs[i].rptr,
                 vecs[i].wen, vecs[i].addr, vecs[i].post);
        end

        // An asynchronous reset mid-cycle, with FULL and OVERFLOW set, clears
        // every output before the next rising edge.
        @(negedge CLK);
        W_INC = 1'b1;
        #2;
        RST = 1'b0;
        #1;
        check("async W_EN",        32'(W_EN),        32'd0);
        check("async W_ADDR",      32'(W_ADDR),      32'd0);
        check("async WPTR_GRAY",   32'(WPTR_GRAY),   32'd0);
        check("async FULL",        32'(FULL),        32'd0);
        check("async ALMOST_FULL", 32'(ALMOST_FULL), 32'd0);
        check("async W_LEVEL",     32'(W_LEVEL),     32'd0);
        check("async OVERFLOW",    32'(OVERFLOW),    32'd0);
        @(negedge CLK);
        RST   = 1'b1;
        W_INC = 1'b0;
        step("post_reset", 1, 4'b0000, 1, 3'd0, mk_exp(4'b0001, 0, 0, 4'd1, 0));

        // Wrap test. The reader trails the writer by two entries, while the
        // write pointer crosses 15 -> 0.
        wr_cnt = 1;
        rd_cnt = 0;
        wr_cnt++;
        step("wrap_prime", 1, to_gray(rd_cnt), 1, 3'd1, mk_exp(to_gray(wr_cnt), 0, 0, 4'd2, 0));
        prev_gray = to_gray(wr_cnt);
        for (int i = 0; i < 20; i++) begin
            wb     = wr_cnt;
            wr_cnt = wr_cnt + 1;
            rd_cnt = wr_cnt - 2;
            lvl    = wr_cnt - rd_cnt;
            e = mk_exp(to_gray(wr_cnt % 16), (lvl == 8), (lvl >= 6), 4'(lvl), 0);
            step($sformatf("wrap%0d", i), 1, to_gray(rd_cnt % 16), 1, 3'(wb % 8), e);
            check($sformatf("wrap%0d gray_one_bit", i),
                  32'($countones(prev_gray ^ WPTR_GRAY)), 32'd1);
            prev_gray = WPTR_GRAY;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
